instr_encoder_loader: RTL

- Inverse of the processor's control decoder: takes symbolic instructions (mnemonic code plus register and immediate fields) over a valid/ready stream.
- Encodes each one into a 32-bit MIPS word and writes it into instruction memory at consecutive word addresses.
- Lets testbenches and the boot path load programs into the single-cycle core without hand-assembled hex.
- The instruction set covered is exactly the set the core decodes.

---
 rtl/mips_isa_pkg.sv | 52 +++++
 rtl/instr_encoder_loader_if.sv | 14 +
 rtl/instr_encode.sv | 59 +++++
 rtl/instr_encoder_loader.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// MIPS opcode/funct constants, mnemonic codes and field positions shared by the
// control decoder and the program loader.
package mips_isa_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpSltiu = 6'h0B;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnXor  = 6'h26;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2A;
    localparam logic [5:0] FnSltu = 6'h2B;

    typedef enum logic [4:0] {
        MnAdd   = 5'd0,  MnAddu  = 5'd1,  MnSub   = 5'd2,  MnSubu  = 5'd3,
        MnAnd   = 5'd4,  MnOr    = 5'd5,  MnXor   = 5'd6,  MnNor   = 5'd7,
        MnSlt   = 5'd8,  MnSltu  = 5'd9,  MnAddi  = 5'd10, MnAddiu = 5'd11,
        MnSlti  = 5'd12, MnSltiu = 5'd13, MnAndi  = 5'd14, MnOri   = 5'd15,
        MnXori  = 5'd16, MnLw    = 5'd17, MnSw    = 5'd18, MnBeq   = 5'd19,
        MnBne   = 5'd20
    } mnem_e;

    localparam int unsigned OpLsb    = 26;
    localparam int unsigned RsLsb    = 21;
    localparam int unsigned RtLsb    = 16;
    localparam int unsigned RdLsb    = 11;
    localparam int unsigned ShamtLsb = 6;
    localparam int unsigned FunctLsb = 0;
    localparam int unsigned ImmLsb   = 0;

    localparam logic [1:0] ErrNone     = 2'd0;
    localparam logic [1:0] ErrIllegal  = 2'd1;
    localparam logic [1:0] ErrOverflow = 2'd2;

    typedef enum logic [1:0] {StIdle, StLoad, StDone, StError} state_e;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Symbolic-instruction stream: valid/ready handshake plus instruction fields.
interface instr_encoder_loader_if;
    logic        valid;
    logic        ready;
    logic [4:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic        last;

    modport master (output valid, mnem, rs, rt, rd, imm, last, input ready);
    modport slave  (input valid, mnem, rs, rt, rd, imm, last, output ready);
endinterface

// File: rtl/instr_encode.sv
// Combinational mnemonic-to-MIPS-word encoder; flags codes outside the decoded set.
module instr_encode
    import mips_isa_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);
    logic [5:0] op;
    logic [5:0] funct;
    logic       rtype;

    always_comb begin
        op      = OpRtype;
        funct   = '0;
        rtype   = 1'b0;
        illegal = 1'b0;
        case (mnem)
            MnAdd:   begin rtype = 1'b1; funct = FnAdd;  end
            MnAddu:  begin rtype = 1'b1; funct = FnAddu; end
            MnSub:   begin rtype = 1'b1; funct = FnSub;  end
            MnSubu:  begin rtype = 1'b1; funct = FnSubu; end
            MnAnd:   begin rtype = 1'b1; funct = FnAnd;  end
            MnOr:    begin rtype = 1'b1; funct = FnOr;   end
            MnXor:   begin rtype = 1'b1; funct = FnXor;  end
            MnNor:   begin rtype = 1'b1; funct = FnNor;  end
            MnSlt:   begin rtype = 1'b1; funct = FnSlt;  end
            MnSltu:  begin rtype = 1'b1; funct = FnSltu; end
            MnAddi:  op = OpAddi;
            MnAddiu: op = OpAddiu;
            MnSlti:  op = OpSlti;
            MnSltiu: op = OpSltiu;
            MnAndi:  op = OpAndi;
            MnOri:   op = OpOri;
            MnXori:  op = OpXori;
            MnLw:    op = OpLw;
            MnSw:    op = OpSw;
            MnBeq:   op = OpBeq;
            MnBne:   op = OpBne;
            default: illegal = 1'b1;
        endcase
    end

    // Only the fields belonging to the format are placed; the rest never reach the word.
    always_comb begin
        word = '0;
        if (rtype) begin
            word = (32'(rs) << RsLsb) | (32'(rt) << RtLsb) | (32'(rd) << RdLsb)
                 | (32'(5'd0) << ShamtLsb) | (32'(funct) << FunctLsb);
        end else if (!illegal) begin
            word = (32'(op) << OpLsb) | (32'(rs) << RsLsb) | (32'(rt) << RtLsb)
                 | (32'(imm) << ImmLsb);
        end
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes streamed symbolic instructions and writes them to
// instruction memory at consecutive word addresses from a latched base.
module instr_encoder_loader
    import mips_isa_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [AW-1:0]          base_addr,
    instr_encoder_loader_if.slave  s,
    output logic                   imem_we,
    output logic [AW-1:0]          imem_addr,
    output logic [31:0]            imem_wdata,
    output logic [15:0]            count,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             err
);
    state_e        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [15:0]   count_q, count_d;
    logic          we_q, we_d;
    logic          done_q, done_d;
    logic [1:0]    err_q, err_d;

    logic [31:0]   enc_word;
    logic          enc_illegal;
    logic          accept;
    logic [16:0]   count_inc;

    instr_encode u_encode (
        .mnem    (s.mnem),
        .rs      (s.rs),
        .rt      (s.rt),
        .rd      (s.rd),
        .imm     (s.imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign accept    = s.valid && (state_q == StLoad);
    assign count_inc = {1'b0, count_q} + 17'd1;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        we_d    = 1'b0;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            StLoad: begin
                if (accept) begin
                    // Illegal mnemonic wins over s_last and overflow: nothing is written.
                    if (enc_illegal) begin
                        state_d = StError;
                        err_d   = ErrIllegal;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = base_q + AW'({count_q, 2'b00});
                        wdata_d = enc_word;
                        count_d = count_inc[15:0];
                        if (s.last) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else if (count_inc == 17'(DEPTH)) begin
                            state_d = StError;
                            err_d   = ErrOverflow;
                        end
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d = StLoad;
                    base_d  = base_addr;
                    count_d = '0;
                    done_d  = 1'b0;
                    err_d   = ErrNone;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            base_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= ErrNone;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign s.ready    = (state_q == StLoad);
    assign busy       = (state_q == StLoad);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign done       = done_q;
    assign err        = err_q;
endmodule
